mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS main controller that sequences the shared datapath: PC, IR, register file, the single ALU and a unified memory port.
- Decodes the IR opcode and steps each instruction through fetch, decode, execute, memory and write-back states.
- Drives the 4-bit ALUOp consumed by the ALU control decoder and honours that decoder's jr flag.
- Supports variable-latency memory through a ready handshake and counts retired instructions.

Parameters:
CNT_W  32  width of retired-instruction counter

Ports:
clk            in   1      system clock, rising edge
rst_n          in   1      synchronous active-low reset
opcode         in   6      IR[31:26], stable from DECODE until the next FETCH completes
jr             in   1      jr flag from ALU control decoder (combinational on IR funct)
mem_ready      in   1      memory completes current read/write this cycle
pc_write       out  1      unconditional PC load
pc_write_cond  out  1      PC load if branch condition true
branch_ne      out  1      1: branch condition is ALU zero==0 (bne); 0: zero==1 (beq)
pc_source      out  2      00 ALU result, 01 ALUOut, 10 jump target, 11 rs register
i_or_d         out  1      memory address: 0 PC, 1 ALUOut
mem_read       out  1      memory read request
mem_write      out  1      memory write request
ir_write       out  1      IR load
reg_dst        out  2      00 rt, 01 rd, 10 $31
mem_to_reg     out  2      write data: 00 ALUOut, 01 MDR, 10 PC
reg_write      out  1      register file write
alu_src_a      out  1      0 PC, 1 register A
alu_src_b      out  2      00 register B, 01 const 4, 10 extended imm, 11 imm<<2
alu_op         out  4      ALUOp to ALU control decoder
state          out  4      current state, debug
instr_done     out  1      one-cycle pulse on retirement
illegal        out  1      one-cycle pulse on unknown opcode
retired        out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n=0 at clk edge): state=FETCH(0), retired=0. While rst_n=0, every output except state/retired is forced to 0.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, IEXEC 8, IWB 9, BRANCH 10, JUMP 11, JRS 12. Codes 13-15 go to FETCH next cycle with all outputs 0.
- Outputs decode combinationally from state (plus mem_ready/opcode where noted). Unlisted outputs are 0.
- ALUOp codes: 0000 add, 0001 sub, 0010 R-type (funct decides), 0011 and, 0100 or, 0101 slt, 0110 addu, 0111 sltu, 1000 lui, 1001 xori.
- FETCH: mem_read=1, alu_src_b=01, alu_op=0000; ir_write=pc_write=mem_ready. Holds while mem_ready=0, else goes to DECODE.
- DECODE: alu_src_b=11, alu_op=0000. Next state by opcode:
  - 000000 -> EXEC
  - 100011/101011 -> MEMADR
  - 000100/000101 -> BRANCH
  - 000010/000011 -> JUMP
  - 001000,001001,001010,001011,001100,001101,001110,001111 -> IEXEC
  - anything else -> FETCH with illegal=1 (not counted)
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=0000. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01. Then FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=0010. jr=1 -> JRS, else RWB.
- RWB: reg_write=1, reg_dst=01, mem_to_reg=00. Then FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10. alu_op by opcode: addi 0000, addiu 0110, slti 0101, sltiu 0111, andi 0011, ori 0100, xori 1001, lui 1000.
- IWB: reg_write=1, reg_dst=00, mem_to_reg=00. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=0001, pc_write_cond=1, pc_source=01, branch_ne=(opcode==000101). Then FETCH.
- JUMP: pc_write=1, pc_source=10. If opcode==000011 (jal): also reg_write=1, reg_dst=10, mem_to_reg=10. Then FETCH.
- JRS: pc_write=1, pc_source=11. Then FETCH.
- Retirement: instr_done=1 in the final cycle of an instruction, i.e. any cycle whose next state is FETCH. This excludes illegal and reset cycles, and excludes MEMWR while mem_ready=0.
- retired increments by 1 on the same edge and wraps modulo 2^CNT_W.
- Reset mid-instruction aborts the instruction with no retirement. mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Latency with mem_ready tied to 1:
  - R-type 4 cycles, jr 4
  - lw 5
  - sw 4
  - I-type ALU 4
  - beq/bne 3
  - j/jal 3

Test Plan:
- Reset, then rst_n=1 with mem_ready=1 and opcode=000000, jr=0 -> states 0,1,6,7,0; alu_op=0010 in EXEC; reg_write=1,reg_dst=01 in RWB; instr_done once; retired=1.
- lw with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_read=1,i_or_d=1; then MEMWB with mem_to_reg=01; total 8 cycles; retired +1.
- opcode=000101 -> states 0,1,10,0; branch_ne=1, pc_write_cond=1, alu_op=0001; retired +1 after 3 cycles.
- opcode=000011 (jal) -> JUMP with pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. Then opcode=000000 with jr=1 -> EXEC then JRS with pc_source=11, reg_write=0.
- Sweep the 8 I-type opcodes -> IEXEC alu_op matches the table; opcode=111111 -> illegal pulse in DECODE, back to FETCH, retired unchanged.
- rst_n=0 during MEMRD -> next state FETCH, outputs 0 while low, retired=0, no instr_done. Preload retired to all-ones via CNT_W=4 build and 16 retirements -> wraps to 0.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: steps each instruction FETCH->DECODE->EXEC/MEM->WB with a unified memory port.
// Outputs decode combinationally from state; FETCH/MEMRD/MEMWR stall on mem_ready=0.
module mc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             jr,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_IEXEC  = 4'd8;
  localparam logic [3:0] S_IWB    = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JRS    = 4'd12;

  localparam logic [3:0] AOP_ADD  = 4'b0000;
  localparam logic [3:0] AOP_SUB  = 4'b0001;
  localparam logic [3:0] AOP_RTYP = 4'b0010;
  localparam logic [3:0] AOP_AND  = 4'b0011;
  localparam logic [3:0] AOP_OR   = 4'b0100;
  localparam logic [3:0] AOP_SLT  = 4'b0101;
  localparam logic [3:0] AOP_ADDU = 4'b0110;
  localparam logic [3:0] AOP_SLTU = 4'b0111;
  localparam logic [3:0] AOP_LUI  = 4'b1000;
  localparam logic [3:0] AOP_XORI = 4'b1001;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [3:0] state_q;
  logic [3:0] next_state;

  assign state = state_q;

  always_comb begin
    next_state    = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = AOP_ADD;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is computed here while the opcode is being decoded.
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:       next_state = S_EXEC;
          OP_LW, OP_SW:   next_state = S_MEMADR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J, OP_JAL:   next_state = S_JUMP;
          6'b001000, 6'b001001, 6'b001010, 6'b001011,
          6'b001100, 6'b001101, 6'b001110, 6'b001111:
                          next_state = S_IEXEC;
          default: begin
            next_state = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        next_state = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = AOP_RTYP;
        next_state = jr ? S_JRS : S_RWB;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b01;
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = S_IWB;
        case (opcode[2:0])
          3'b000:  alu_op = AOP_ADD;
          3'b001:  alu_op = AOP_ADDU;
          3'b010:  alu_op = AOP_SLT;
          3'b011:  alu_op = AOP_SLTU;
          3'b100:  alu_op = AOP_AND;
          3'b101:  alu_op = AOP_OR;
          3'b110:  alu_op = AOP_XORI;
          default: alu_op = AOP_LUI;
        endcase
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = AOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == OP_BNE);
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end
      S_JRS: begin
        pc_write   = 1'b1;
        pc_source  = 2'b11;
        instr_done = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase

    // Reset masks every control output so the datapath is quiescent while held.
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      pc_source     = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 2'b00;
      mem_to_reg    = 2'b00;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = AOP_ADD;
      instr_done    = 1'b0;
      illegal       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      state_q <= next_state;
      if (instr_done)
        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized instruction-level bench: builds each instruction's expected state trace and compares per cycle.
module tb_mc_ctrl_fsm;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          jr;
  logic          mem_ready;
  logic          pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
  logic          reg_write, alu_src_a, instr_done, illegal;
  logic [1:0]    pc_source, reg_dst, mem_to_reg, alu_src_b;
  logic [3:0]    alu_op, state;
  logic [CW-1:0] retired;

  mc_ctrl_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .jr(jr), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
    .instr_done(instr_done), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cnt   = 0;

  typedef struct {
    logic [3:0] st;
    logic       mr;
  } cyc_t;

  logic [3:0] itype_aop [8] = '{4'h0, 4'h6, 4'h5, 4'h7, 4'h3, 4'h4, 4'h9, 4'h8};
  logic [5:0] legal_ops [16] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08,
                                 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h00};

  wire [22:0] dut_vec = {pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read,
                         mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                         alu_src_b, alu_op, instr_done, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Control word the datapath needs in each step, straight from the step descriptions.
  function automatic logic [20:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                           input logic mr);
    logic pw, pwc, bne, iod, mrd, mwr, irw, rw, asa;
    logic [1:0] ps, rd, mtr, asb;
    logic [3:0] aop;
    {pw, pwc, bne, iod, mrd, mwr, irw, rw, asa} = '0;
    {ps, rd, mtr, asb} = '0;
    aop = 4'h0;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; pw = mr; irw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin rw = 1; mtr = 2'b01; end
      4'd5:  begin mwr = 1; iod = 1; end
      4'd6:  begin asa = 1; aop = 4'h2; end
      4'd7:  begin rw = 1; rd = 2'b01; end
      4'd8:  begin asa = 1; asb = 2'b10; aop = itype_aop[op[2:0]]; end
      4'd9:  rw = 1;
      4'd10: begin asa = 1; aop = 4'h1; pwc = 1; ps = 2'b01; bne = (op == 6'h05); end
      4'd11: begin
        pw = 1; ps = 2'b10;
        if (op == 6'h03) begin rw = 1; rd = 2'b10; mtr = 2'b10; end
      end
      4'd12: begin pw = 1; ps = 2'b11; end
      default: ;
    endcase
    return {pw, pwc, bne, ps, iod, mrd, mwr, irw, rd, mtr, rw, asa, asb, aop};
  endfunction

  // Runs one instruction; abort_at >= 0 asserts reset in that cycle of the trace.
  task automatic run_instr(input logic [5:0] op, input logic jrv, input int fs, input int ms,
                           input int abort_at);
    cyc_t tr[$];
    bit   legal;
    bit   done;
    for (int k = 0; k < fs; k++) tr.push_back('{4'd0, 1'b0});
    tr.push_back('{4'd0, 1'b1});
    tr.push_back('{4'd1, 1'($urandom)});
    legal = 1;
    case (op)
      6'h00: begin
        tr.push_back('{4'd6, 1'($urandom)});
        tr.push_back('{jrv ? 4'd12 : 4'd7, 1'($urandom)});
      end
      6'h23: begin
        tr.push_back('{4'd2, 1'($urandom)});
        for (int k = 0; k < ms; k++) tr.push_back('{4'd3, 1'b0});
        tr.push_back('{4'd3, 1'b1});
        tr.push_back('{4'd4, 1'($urandom)});
      end
      6'h2b: begin
        tr.push_back('{4'd2, 1'($urandom)});
        for (int k = 0; k < ms; k++) tr.push_back('{4'd5, 1'b0});
        tr.push_back('{4'd5, 1'b1});
      end
      6'h04, 6'h05: tr.push_back('{4'd10, 1'($urandom)});
      6'h02, 6'h03: tr.push_back('{4'd11, 1'($urandom)});
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        tr.push_back('{4'd8, 1'($urandom)});
        tr.push_back('{4'd9, 1'($urandom)});
      end
      default: legal = 0;
    endcase
    for (int i = 0; i < tr.size(); i++) begin
      opcode    = op;
      jr        = jrv;
      mem_ready = tr[i].mr;
      rst_n     = (i != abort_at);
      done      = legal && (i == tr.size() - 1) && (i != abort_at);
      @(negedge clk);
      check("state", 32'(state), 32'(tr[i].st));
      if (i == abort_at)
        check("ctrl_in_reset", 32'(dut_vec), 32'd0);
      else
        check("ctrl", 32'(dut_vec),
              32'({exp_ctrl(tr[i].st, op, tr[i].mr), done, !legal && tr[i].st == 4'd1}));
      check("retired", 32'(retired), 32'(cnt % (1 << CW)));
      @(posedge clk);
      #1;
      if (i == abort_at) begin
        cnt   = 0;
        rst_n = 1'b1;
        check("state_after_abort", 32'(state), 32'd0);
        return;
      end
      if (done) cnt++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'h00;
    jr        = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctrl", 32'(dut_vec), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;

    run_instr(6'h00, 1'b0, 0, 0, -1);
    check("first_retired", 32'(retired), 32'd1);
    run_instr(6'h23, 1'b0, 0, 3, -1);
    run_instr(6'h2b, 1'b0, 1, 2, -1);
    run_instr(6'h05, 1'b0, 0, 0, -1);
    run_instr(6'h04, 1'b1, 0, 0, -1);
    run_instr(6'h03, 1'b0, 0, 0, -1);
    run_instr(6'h00, 1'b1, 0, 0, -1);
    for (int k = 8; k < 16; k++) run_instr(6'(k), 1'b0, 0, 0, -1);
    run_instr(6'h3f, 1'b0, 0, 0, -1);
    run_instr(6'h23, 1'b0, 0, 2, 3);

    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      int         ab;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 15)];
      ab = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
